// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mips_bus_arbiter
// Purpose  : Shares the single Avalon-MM master port of mips_cpu_bus between
//            instruction fetch (port 0) and data access (port 1). One transfer
//            at a time; arbitration takes one idle cycle, and the owner's
//            strobes are forwarded combinationally until completion.
// Ports    : clk, reset (async, active-high)
//            rq_*_0 / rq_*_1 : requester address/read/write/writedata/
//                              byteenable in, waitrequest/readdata out
//            address/read/write/writedata/byteenable : Avalon master out
//            waitrequest/readdata : Avalon slave response in
//            grant : one-hot current owner, 2'b00 when idle
// Config   : MIPS_BUS_ARB_RR_EN defined  -> round-robin on ties
//            MIPS_BUS_ARB_RR_EN undefined -> port 1 wins ties
// Revision : 1.0 - initial release
// ============================================================================
module mips_bus_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   rq_address_0,
  input  logic                rq_read_0,
  input  logic                rq_write_0,
  input  logic [DATA_W-1:0]   rq_writedata_0,
  input  logic [DATA_W/8-1:0] rq_byteenable_0,
  output logic                rq_waitrequest_0,
  output logic [DATA_W-1:0]   rq_readdata_0,
  input  logic [ADDR_W-1:0]   rq_address_1,
  input  logic                rq_read_1,
  input  logic                rq_write_1,
  input  logic [DATA_W-1:0]   rq_writedata_1,
  input  logic [DATA_W/8-1:0] rq_byteenable_1,
  output logic                rq_waitrequest_1,
  output logic [DATA_W-1:0]   rq_readdata_1,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic                waitrequest,
  input  logic [DATA_W-1:0]   readdata,
  output logic [1:0]          grant
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  logic [1:0] state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic       pend0, pend1;
  logic       winner;

  assign pend0 = rq_read_0 | rq_write_0;
  assign pend1 = rq_read_1 | rq_write_1;

  // Tie-break only matters when both ports are pending in IDLE.
`ifdef MIPS_BUS_ARB_RR_EN
  assign winner = (pend0 && pend1) ? ~last_owner_q : pend1;
`else
  assign winner = pend1;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Next-state logic. Completion and a dropped strobe both return to IDLE,
  // so there is never a back-to-back grant; only completion updates
  // last_owner.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (pend0 || pend1) begin
          state_d = winner ? ST_OWN1 : ST_OWN0;
        end
      end
      ST_OWN0: begin
        if (!pend0) begin
          state_d = ST_IDLE;
        end else if (!waitrequest) begin
          state_d      = ST_IDLE;
          last_owner_d = 1'b0;
        end
      end
      ST_OWN1: begin
        if (!pend1) begin
          state_d = ST_IDLE;
        end else if (!waitrequest) begin
          state_d      = ST_IDLE;
          last_owner_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic. Bus outputs depend only on the registered state and the
  // owner's inputs, so an async reset of state_q drops the strobes at once.
  // When a requester raises both strobes the write is forwarded, the read
  // is dropped.
  always_comb begin
    address          = '0;
    read             = 1'b0;
    write            = 1'b0;
    writedata        = '0;
    byteenable       = '0;
    rq_waitrequest_0 = 1'b1;
    rq_waitrequest_1 = 1'b1;
    rq_readdata_0    = '0;
    rq_readdata_1    = '0;
    grant            = 2'b00;
    case (state_q)
      ST_OWN0: begin
        grant            = 2'b01;
        address          = rq_address_0;
        write            = rq_write_0;
        read             = rq_read_0 & ~rq_write_0;
        writedata        = rq_writedata_0;
        byteenable       = rq_byteenable_0;
        rq_waitrequest_0 = waitrequest;
        rq_readdata_0    = readdata;
      end
      ST_OWN1: begin
        grant            = 2'b10;
        address          = rq_address_1;
        write            = rq_write_1;
        read             = rq_read_1 & ~rq_write_1;
        writedata        = rq_writedata_1;
        byteenable       = rq_byteenable_1;
        rq_waitrequest_1 = waitrequest;
        rq_readdata_1    = readdata;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_bus_arbiter
// Purpose  : Directed self-checking bench for mips_bus_arbiter. Expected
//            values follow the tie-break selected by MIPS_BUS_ARB_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_bus_arbiter;

`ifdef MIPS_BUS_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rq_address_0, rq_address_1;
  logic        rq_read_0, rq_read_1, rq_write_0, rq_write_1;
  logic [31:0] rq_writedata_0, rq_writedata_1;
  logic [3:0]  rq_byteenable_0, rq_byteenable_1;
  logic        rq_waitrequest_0, rq_waitrequest_1;
  logic [31:0] rq_readdata_0, rq_readdata_1;
  logic [31:0] address;
  logic        read, write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .rq_address_0(rq_address_0), .rq_read_0(rq_read_0), .rq_write_0(rq_write_0),
    .rq_writedata_0(rq_writedata_0), .rq_byteenable_0(rq_byteenable_0),
    .rq_waitrequest_0(rq_waitrequest_0), .rq_readdata_0(rq_readdata_0),
    .rq_address_1(rq_address_1), .rq_read_1(rq_read_1), .rq_write_1(rq_write_1),
    .rq_writedata_1(rq_writedata_1), .rq_byteenable_1(rq_byteenable_1),
    .rq_waitrequest_1(rq_waitrequest_1), .rq_readdata_1(rq_readdata_1),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
    .grant(grant)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    rq_address_0 = 32'hBFC00000; rq_address_1 = 32'h00002000;
    rq_read_0 = 1'b1; rq_read_1 = 1'b1; rq_write_0 = 1'b0; rq_write_1 = 1'b0;
    rq_writedata_0 = 32'h0; rq_writedata_1 = 32'h0;
    rq_byteenable_0 = 4'hF; rq_byteenable_1 = 4'hF;
    waitrequest = 1'b0; readdata = 32'h12345678;

    // 1: reset held with both reads pending
    cyc(); cyc(); #1;
    chk("rst_read", {31'b0, read}, 32'd0);
    chk("rst_write", {31'b0, write}, 32'd0);
    chk("rst_grant", {30'b0, grant}, 32'd0);
    chk("rst_wait0", {31'b0, rq_waitrequest_0}, 32'd1);
    chk("rst_wait1", {31'b0, rq_waitrequest_1}, 32'd1);
    chk("rst_addr", address, 32'd0);

    // 2: port0 single read, zero wait states
    rq_read_0 = 1'b0; rq_read_1 = 1'b0;
    cyc();
    reset = 1'b0; rq_read_0 = 1'b1; #1;
    chk("t2_c1_read", {31'b0, read}, 32'd0);
    chk("t2_c1_wait0", {31'b0, rq_waitrequest_0}, 32'd1);
    cyc(); #1;
    chk("t2_c2_read", {31'b0, read}, 32'd1);
    chk("t2_c2_addr", address, 32'hBFC00000);
    chk("t2_c2_rdata0", rq_readdata_0, 32'h12345678);
    chk("t2_c2_wait0", {31'b0, rq_waitrequest_0}, 32'd0);
    chk("t2_c2_grant", {30'b0, grant}, 32'd1);
    cyc();
    rq_read_0 = 1'b0; #1;
    chk("t2_c3_grant", {30'b0, grant}, 32'd0);
    chk("t2_c3_read", {31'b0, read}, 32'd0);

    // 3: tie after reset (last_owner = 1)
    reset = 1'b1; #1; reset = 1'b0;
    rq_read_0 = 1'b1; rq_read_1 = 1'b1; #1;
    chk("t3_idle_grant", {30'b0, grant}, 32'd0);
    cyc(); #1;
    chk("t3_first_grant", {30'b0, grant}, RR ? 32'd1 : 32'd2);
    chk("t3_first_addr", address, RR ? 32'hBFC00000 : 32'h00002000);
    chk("t3_other_wait", {31'b0, RR ? rq_waitrequest_1 : rq_waitrequest_0}, 32'd1);
    chk("t3_other_rdata", RR ? rq_readdata_1 : rq_readdata_0, 32'd0);
    cyc();
    if (RR) rq_read_0 = 1'b0; else rq_read_1 = 1'b0;
    #1;
    chk("t3_gap_grant", {30'b0, grant}, 32'd0);
    cyc(); #1;
    chk("t3_second_grant", {30'b0, grant}, RR ? 32'd2 : 32'd1);
    cyc();
    rq_read_0 = 1'b0; rq_read_1 = 1'b0; #1;
    chk("t3_end_grant", {30'b0, grant}, 32'd0);

    // 4: port1 write stalled 3 cycles, port0 read arrives meanwhile
    rq_write_1 = 1'b1; rq_address_1 = 32'h00001000;
    rq_writedata_1 = 32'hDEADBEEF; rq_byteenable_1 = 4'b0011;
    waitrequest = 1'b1;
    cyc();
    rq_read_0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) waitrequest = 1'b0;
      #1;
      chk($sformatf("t4_write_%0d", i), {31'b0, write}, 32'd1);
      chk($sformatf("t4_addr_%0d", i), address, 32'h00001000);
      chk($sformatf("t4_data_%0d", i), writedata, 32'hDEADBEEF);
      chk($sformatf("t4_be_%0d", i), {28'b0, byteenable}, 32'h3);
      chk($sformatf("t4_wait0_%0d", i), {31'b0, rq_waitrequest_0}, 32'd1);
      chk($sformatf("t4_wait1_%0d", i), {31'b0, rq_waitrequest_1}, (i == 3) ? 32'd0 : 32'd1);
      if (i < 3) cyc();
    end
    cyc();
    rq_write_1 = 1'b0; waitrequest = 1'b1; #1;
    chk("t4_idle_grant", {30'b0, grant}, 32'd0);
    chk("t4_idle_wait0", {31'b0, rq_waitrequest_0}, 32'd1);

    // 5: port0 owns, then abandons its read while stalled
    cyc(); #1;
    chk("t5_own_grant", {30'b0, grant}, 32'd1);
    chk("t5_own_read", {31'b0, read}, 32'd1);
    rq_read_0 = 1'b0; #1;
    chk("t5_drop_read", {31'b0, read}, 32'd0);
    cyc();
    rq_read_0 = 1'b1; rq_read_1 = 1'b1; waitrequest = 1'b0; #1;
    chk("t5_idle_grant", {30'b0, grant}, 32'd0);
    cyc(); #1;
    // last_owner must still be 1 from the completed port1 write
    chk("t5_regrant", {30'b0, grant}, RR ? 32'd1 : 32'd2);
    cyc();
    rq_read_0 = 1'b0; rq_read_1 = 1'b0; #1;
    chk("t5_end_grant", {30'b0, grant}, 32'd0);

    // 6: async reset during a stalled port1 write
    reset = 1'b1; #1; reset = 1'b0;
    rq_write_1 = 1'b1; waitrequest = 1'b1;
    cyc(); #1;
    chk("t6_own_write", {31'b0, write}, 32'd1);
    chk("t6_own_grant", {30'b0, grant}, 32'd2);
    #2; reset = 1'b1; #1;
    chk("t6_rst_write", {31'b0, write}, 32'd0);
    chk("t6_rst_grant", {30'b0, grant}, 32'd0);
    cyc();
    reset = 1'b0; rq_read_0 = 1'b1; #1;
    chk("t6_idle_grant", {30'b0, grant}, 32'd0);
    cyc(); #1;
    chk("t6_rearb_grant", {30'b0, grant}, RR ? 32'd1 : 32'd2);
    rq_read_0 = 1'b0; rq_write_1 = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
